// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO = 0;

    // Low bit of port k's field in a packed multi-port bus of per-port width w.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits with write-clear / mark-set priority and a
// registered population count kept in step with the bit transitions.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we0_i,
    input  logic [ADDR_W-1:0]       wa0_i,
    input  logic                    we1_i,
    input  logic [ADDR_W-1:0]       wa1_i,
    input  logic                    mark_en_i,
    input  logic [ADDR_W-1:0]       mark_addr_i,
    output logic [(1<<ADDR_W)-1:0]  pend_o,
    output logic [ADDR_W:0]         pend_cnt_o
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0] pend_q, pend_d;
    logic [NREGS-1:0] clr_mask, set_mask;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             mark_ok, fall0, fall1, rise;

    assign mark_ok = mark_en_i && (mark_addr_i != ADDR_W'(REG_ZERO));

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (we0_i) clr_mask[wa0_i] = 1'b1;
        if (we1_i) clr_mask[wa1_i] = 1'b1;
        if (mark_ok) set_mask[mark_addr_i] = 1'b1;
        // Clear first, then set: a new producer outranks a same-cycle writeback.
        pend_d    = (pend_q & ~clr_mask) | set_mask;
        pend_d[0] = 1'b0;
    end

    // Count only genuine transitions; a doubly-written address falls once.
    always_comb begin
        fall0 = we0_i && pend_q[wa0_i] && !pend_d[wa0_i];
        fall1 = we1_i && !(we0_i && (wa1_i == wa0_i)) && pend_q[wa1_i] && !pend_d[wa1_i];
        rise  = mark_ok && !pend_q[mark_addr_i];
        cnt_d = cnt_q - {{ADDR_W{1'b0}}, fall0} - {{ADDR_W{1'b0}}, fall1}
                      + {{ADDR_W{1'b0}}, rise};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_o     = pend_q;
    assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read, dual-write register file (r0 hardwired to zero) with optional
// write-to-read bypass and a pending-write scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [0:NREGS-1];
    logic [NREGS-1:0]  pend_vec;

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            if (we0 && (wa0 != ZERO_A)) regs_q[wa0] <= wd0;
            if (we1 && (wa1 != ZERO_A)) regs_q[wa1] <= wd1;
        end
    end

    rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .we0_i       (we0),
        .wa0_i       (wa0),
        .we1_i       (we1),
        .wa1_i       (wa1),
        .mark_en_i   (mark_en),
        .mark_addr_i (mark_addr),
        .pend_o      (pend_vec),
        .pend_cnt_o  (pend_cnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data;
            logic              pend, hit0, hit1, mark_hit;

            assign addr     = rd_addr[slice_lo(gi, ADDR_W) +: ADDR_W];
            assign hit0     = we0 && (wa0 == addr);
            assign hit1     = we1 && (wa1 == addr);
            assign mark_hit = mark_en && (mark_addr == addr);

            always_comb begin
                data = regs_q[addr];
                pend = pend_vec[addr];
                if (addr == ZERO_A) begin
                    data = '0;
                    pend = 1'b0;
                end else if (BYPASS != 0) begin
                    if (hit1)      data = wd1;
                    else if (hit0) data = wd0;
                    if ((hit0 || hit1) && !mark_hit) pend = 1'b0;
                end
            end

            assign rd_data[slice_lo(gi, DATA_W) +: DATA_W] = data;
            assign rd_pend[gi] = pend;
        end
    endgenerate

endmodule
